// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM stream reader; encodings come from the defs header.
package bram_stream_reader_pkg;
`include "bram_reader_defs.vh"

  typedef enum logic [1:0] {
    IDLE  = `BRAM_READER_IDLE,
    RUN   = `BRAM_READER_RUN,
    DRAIN = `BRAM_READER_DRAIN
  } state_t;

endpackage

// File: rtl/bram_reader_defs.vh
// State encodings shared by the BRAM stream reader sources.
`ifndef BRAM_READER_DEFS_VH
`define BRAM_READER_DEFS_VH

`define BRAM_READER_IDLE  2'd0
`define BRAM_READER_RUN   2'd1
`define BRAM_READER_DRAIN 2'd2

`endif

// File: rtl/skid_buffer2.sv
// Two-entry FIFO holding BRAM read data until the stream consumer takes it.
module skid_buffer2
  import bram_stream_reader_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            valid,
  output logic [1:0]      occupancy
);

  logic [XLEN-1:0] head;
  logic [XLEN-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) head <= din;
          else                   tail <= din;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head      <= tail;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind whatever remains.
          if (occupancy == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign valid = (occupancy != 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a burst of consecutive BRAM words out over a valid/ready port.
// Define BRAM_READER_WRAP_EN to let bursts wrap past the top of memory instead of rejecting them.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int memSize_p = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [memSize_p-1:0] base_i,
  input  logic [memSize_p:0]   len_i,
  output logic                 mem_read_o,
  output logic [memSize_p-1:0] mem_raddr_o,
  input  logic [XLEN-1:0]      mem_data_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CW = memSize_p + 1;

  state_t               state;
  logic [memSize_p-1:0] addr;
  logic [CW-1:0]        reads_left;
  logic [CW-1:0]        words_left;
  logic                 inflight;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [1:0]           occupancy;
  logic                 pop;
  logic                 rd;
  logic                 range_err;

`ifdef BRAM_READER_WRAP_EN
  assign range_err = 1'b0;
`else
  localparam logic [CW-1:0] DEPTH = {1'b1, {memSize_p{1'b0}}};
  logic [CW-1:0] end_addr;
  assign end_addr  = {1'b0, base_i} + len_i;
  assign range_err = (end_addr > DEPTH);
`endif

  assign pop = valid_o && ready_i;
  // A read issued now lands in the buffer next cycle, so leave room for it and any read still in flight.
  assign rd  = (state == RUN) &&
               (({1'b0, occupancy} - {2'b00, pop} + {2'b00, inflight}) < 3'd2);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      addr       <= '0;
      reads_left <= '0;
      words_left <= '0;
      inflight   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      inflight <= rd;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done <= 1'b1;
            end else if (range_err) begin
              err <= 1'b1;
            end else begin
              state      <= RUN;
              addr       <= base_i;
              reads_left <= len_i;
              words_left <= len_i;
              busy       <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd) begin
            addr       <= addr + memSize_p'(1);
            reads_left <= reads_left - CW'(1);
            if (reads_left == CW'(1)) state <= DRAIN;
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase
      if (busy && pop) begin
        words_left <= words_left - CW'(1);
        if (words_left == CW'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  skid_buffer2 #(.XLEN(XLEN)) u_buf (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (inflight),
    .pop       (pop),
    .din       (mem_data_i),
    .dout      (data_o),
    .valid     (valid_o),
    .occupancy (occupancy)
  );

  assign mem_read_o  = rd;
  assign mem_raddr_o = addr;
  assign busy_o      = busy;
  assign done_o      = done;
  assign err_o       = err;

endmodule
